// File: rtl/md_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_sched_if : EX/D-stage handshake bundle for the MD scheduler        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface md_sched_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use_d;
  logic [1:0]  rd_sel_ex;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  res_sel;
  logic        err_ovlp;

  modport master (
    output start, md_op, rs_val, rt_val, md_use_d, rd_sel_ex,
    input  busy, stall_req, hi, lo, res_sel, err_ovlp
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, md_use_d, rd_sel_ex,
    output busy, stall_req, hi, lo, res_sel, err_ovlp
  );
endinterface
`default_nettype wire

// File: rtl/md_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_sched : MIPS multiply/divide scheduler with fixed-latency HI/LO    |
// |            commit, D-stage stall request and EX result select.       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module md_sched #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  md_sched_if.slave  md
);

  localparam logic [2:0] c_op_mult  = 3'd1;
  localparam logic [2:0] c_op_multu = 3'd2;
  localparam logic [2:0] c_op_div   = 3'd3;
  localparam logic [2:0] c_op_divu  = 3'd4;
  localparam logic [2:0] c_op_mthi  = 3'd5;
  localparam logic [2:0] c_op_mtlo  = 3'd6;

  localparam logic [CNT_W-1:0] c_mult_init = CNT_W'(MULT_CYC - 1);
  localparam logic [CNT_W-1:0] c_div_init  = CNT_W'(DIV_CYC - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_sh_hi;
  logic [31:0]      r_sh_lo;
  logic             r_busy;
  logic             r_err;

  logic        w_is_arith;
  logic        w_is_div;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_is_arith = (md.md_op >= c_op_mult) && (md.md_op <= c_op_divu);
  assign w_is_div   = (md.md_op == c_op_div) || (md.md_op == c_op_divu);

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign w_prod_s = {{32{md.rs_val[31]}}, md.rs_val} * {{32{md.rt_val[31]}}, md.rt_val};
  assign w_prod_u = {32'd0, md.rs_val} * {32'd0, md.rt_val};

  // Signed divide through magnitudes; 0x80000000 / -1 falls out as LO=0x80000000, HI=0.
  assign w_neg_a = md.rs_val[31];
  assign w_neg_b = md.rt_val[31];
  assign w_abs_a = w_neg_a ? (~md.rs_val + 32'd1) : md.rs_val;
  assign w_abs_b = w_neg_b ? (~md.rt_val + 32'd1) : md.rt_val;
  assign w_uq    = (w_abs_b == 32'd0) ? 32'd0 : (w_abs_a / w_abs_b);
  assign w_ur    = (w_abs_b == 32'd0) ? 32'd0 : (w_abs_a % w_abs_b);
  assign w_sq    = (w_neg_a ^ w_neg_b) ? (~w_uq + 32'd1) : w_uq;
  assign w_sr    = w_neg_a ? (~w_ur + 32'd1) : w_ur;

  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    case (md.md_op)
      c_op_mult: begin
        w_res_hi = w_prod_s[63:32];
        w_res_lo = w_prod_s[31:0];
      end
      c_op_multu: begin
        w_res_hi = w_prod_u[63:32];
        w_res_lo = w_prod_u[31:0];
      end
      c_op_div: begin
        if (md.rt_val != 32'd0) begin
          w_res_hi = w_sr;
          w_res_lo = w_sq;
        end
      end
      c_op_divu: begin
        if (md.rt_val != 32'd0) begin
          w_res_hi = md.rs_val % md.rt_val;
          w_res_lo = md.rs_val / md.rt_val;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_sh_hi <= '0;
      r_sh_lo <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (md.start) begin
            if (w_is_arith) begin
              r_sh_hi <= w_res_hi;
              r_sh_lo <= w_res_lo;
              r_cnt   <= w_is_div ? c_div_init : c_mult_init;
              r_state <= S_BUSY;
              r_busy  <= 1'b1;
            end else if (md.md_op == c_op_mthi) begin
              r_hi <= md.rs_val;
            end else if (md.md_op == c_op_mtlo) begin
              r_lo <= md.rs_val;
            end
          end
        end
        S_BUSY: begin
          if (md.start) begin
            r_err <= 1'b1;
          end
          if (r_cnt == '0) begin
            r_hi    <= r_sh_hi;
            r_lo    <= r_sh_lo;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign md.busy      = r_busy;
  assign md.hi        = r_hi;
  assign md.lo        = r_lo;
  assign md.err_ovlp  = r_err;
  assign md.stall_req = md.md_use_d & (r_busy | (md.start & w_is_arith));
  assign md.res_sel   = (md.rd_sel_ex == 2'b11) ? 2'b00 : md.rd_sel_ex;

endmodule
`default_nettype wire

// File: tb/tb_md_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_md_sched : self-checking bench for md_sched                        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_md_sched;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;
  localparam int NV       = 13;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        exp_stall;
    int          ncyc;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  vec_t vecs[NV];
  logic [63:0] sb_q[$];

  md_sched_if bus ();

  md_sched #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] exp;
    logic [1:0]  rs_tab[4];
    int          n;

    n_checks = 0;
    n_fail   = 0;

    //           op    rs            rt            stall ncyc      exp_hi        exp_lo
    vecs[0]  = '{3'd1, 32'hFFFFFFFD, 32'h00000007, 1'b1, MULT_CYC, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 1'b1, MULT_CYC, 32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 1'b1, DIV_CYC,  32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'd3, 32'h00000055, 32'h00000000, 1'b1, DIV_CYC,  32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{3'd5, 32'h00001234, 32'h00000000, 1'b0, 0,        32'h00001234, 32'hFFFFFFFD};
    vecs[5]  = '{3'd6, 32'h00005678, 32'h00000000, 1'b0, 0,        32'h00001234, 32'h00005678};
    vecs[6]  = '{3'd4, 32'h00000064, 32'h00000007, 1'b1, DIV_CYC,  32'h00000002, 32'h0000000E};
    vecs[7]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1, DIV_CYC,  32'h00000000, 32'h80000000};
    vecs[8]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 1'b1, DIV_CYC,  32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, MULT_CYC, 32'h00000000, 32'h00000001};
    vecs[10] = '{3'd2, 32'h80000000, 32'h80000000, 1'b1, MULT_CYC, 32'h40000000, 32'h00000000};
    vecs[11] = '{3'd0, 32'hDEADBEEF, 32'h00000003, 1'b0, 0,        32'h40000000, 32'h00000000};
    vecs[12] = '{3'd4, 32'hDEADBEEF, 32'h00000000, 1'b1, DIV_CYC,  32'h40000000, 32'h00000000};

    rs_tab[0] = 2'b00;
    rs_tab[1] = 2'b01;
    rs_tab[2] = 2'b10;
    rs_tab[3] = 2'b00;

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.md_op     = 3'd0;
    bus.rs_val    = 32'd0;
    bus.rt_val    = 32'd0;
    bus.md_use_d  = 1'b0;
    bus.rd_sel_ex = 2'b00;
    tick();
    tick();
    check("rst_busy",   {63'd0, bus.busy},      64'd0);
    check("rst_stall",  {63'd0, bus.stall_req}, 64'd0);
    check("rst_hi",     {32'd0, bus.hi},        64'd0);
    check("rst_lo",     {32'd0, bus.lo},        64'd0);
    check("rst_err",    {63'd0, bus.err_ovlp},  64'd0);
    check("rst_ressel", {62'd0, bus.res_sel},   64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      bus.md_op    = vecs[i].op;
      bus.rs_val   = vecs[i].rs;
      bus.rt_val   = vecs[i].rt;
      bus.md_use_d = 1'b1;
      bus.start    = 1'b1;
      #1;
      check($sformatf("v%0d_stall_start", i), {63'd0, bus.stall_req}, {63'd0, vecs[i].exp_stall});
      sb_q.push_back({vecs[i].exp_hi, vecs[i].exp_lo});
      tick();
      bus.start = 1'b0;
      bus.md_op = 3'd0;
      n = 0;
      while (bus.busy && n < 50) begin
        n++;
        check($sformatf("v%0d_stall_busy", i), {63'd0, bus.stall_req}, 64'd1);
        tick();
      end
      check($sformatf("v%0d_busy_cycles", i), 64'(n), 64'(vecs[i].ncyc));
      check($sformatf("v%0d_stall_after", i), {63'd0, bus.stall_req}, 64'd0);
      exp = sb_q.pop_front();
      check($sformatf("v%0d_hi", i), {32'd0, bus.hi}, {32'd0, exp[63:32]});
      check($sformatf("v%0d_lo", i), {32'd0, bus.lo}, {32'd0, exp[31:0]});
    end
    check("err_clear_before_ovlp", {63'd0, bus.err_ovlp}, 64'd0);

    // Overlap: a DIV start arrives during the MULT busy window and must be dropped.
    bus.md_use_d = 1'b0;
    bus.md_op    = 3'd1;
    bus.rs_val   = 32'd3;
    bus.rt_val   = 32'd4;
    bus.start    = 1'b1;
    sb_q.push_back({32'd0, 32'd12});
    tick();
    bus.start = 1'b0;
    bus.md_op = 3'd0;
    n = 0;
    while (bus.busy && n < 50) begin
      n++;
      if (n == 1) check("stall_no_use_d", {63'd0, bus.stall_req}, 64'd0);
      bus.start  = (n == 2);
      bus.md_op  = (n == 2) ? 3'd3 : 3'd0;
      bus.rs_val = 32'd100;
      bus.rt_val = 32'd5;
      tick();
    end
    bus.start = 1'b0;
    bus.md_op = 3'd0;
    check("ovlp_busy_cycles", 64'(n), 64'(MULT_CYC));
    exp = sb_q.pop_front();
    check("ovlp_hi",  {32'd0, bus.hi}, {32'd0, exp[63:32]});
    check("ovlp_lo",  {32'd0, bus.lo}, {32'd0, exp[31:0]});
    check("ovlp_err", {63'd0, bus.err_ovlp}, 64'd1);
    tick();
    tick();
    check("ovlp_no_second_op", {63'd0, bus.busy}, 64'd0);
    check("ovlp_err_sticky",   {63'd0, bus.err_ovlp}, 64'd1);

    // Reset in the third busy cycle abandons the op.
    bus.md_op  = 3'd1;
    bus.rs_val = 32'd5;
    bus.rt_val = 32'd6;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.md_op = 3'd0;
    tick();
    tick();
    check("midrst_busy_before", {63'd0, bus.busy}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {63'd0, bus.busy},     64'd0);
    check("midrst_hi",   {32'd0, bus.hi},       64'd0);
    check("midrst_lo",   {32'd0, bus.lo},       64'd0);
    check("midrst_err",  {63'd0, bus.err_ovlp}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.md_op  = 3'd5;
    bus.rs_val = 32'h00001234;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.md_op = 3'd0;
    check("post_rst_mthi_hi",   {32'd0, bus.hi},   64'h1234);
    check("post_rst_mthi_lo",   {32'd0, bus.lo},   64'd0);
    check("post_rst_mthi_busy", {63'd0, bus.busy}, 64'd0);
    tick();
    tick();
    check("post_rst_idle", {63'd0, bus.busy}, 64'd0);

    for (int r = 0; r < 4; r++) begin
      bus.rd_sel_ex = 2'(r);
      #1;
      check($sformatf("res_sel_%0d", r), {62'd0, bus.res_sel}, {62'd0, rs_tab[r]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
